// File: rtl/sim_ctrl_pkg.sv
// Shared types and signature helpers for the simulation run controller.
// Helpers work on a 64-bit carrier; callers truncate to their own data width.
package sim_ctrl_pkg;

   typedef enum logic [1:0] {StHold, StRun, StDone, StTimeout} run_state_e;

   localparam int unsigned MaxDataW = 64;
   localparam int unsigned MaxStrbW = MaxDataW / 8;

   function automatic logic [MaxDataW-1:0] byte_mask(input logic [MaxStrbW-1:0] wstrb);
      logic [MaxDataW-1:0] m;
      for (int i = 0; i < MaxStrbW; i++) begin
         m[i*8 +: 8] = {8{wstrb[i]}};
      end
      return m;
   endfunction

   // Rotate left by one within 'width' bits, then xor in the masked data.
   function automatic logic [MaxDataW-1:0] sig_step(input logic [MaxDataW-1:0] sig,
                                                    input logic [MaxDataW-1:0] masked,
                                                    input int unsigned        width);
      logic [MaxDataW-1:0] rot;
      rot = (sig << 1) | ((sig >> (width - 1)) & MaxDataW'(1));
      return rot ^ masked;
   endfunction

endpackage

// File: rtl/write_signature.sv
// Byte-masked rotate-xor signature register with enable and synchronous clear.
// Generic enough to also sign read data.
module write_signature
   import sim_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                en,
   input  logic                clr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   sig
);

   logic [DATA_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = DATA_W'(sig_step(MaxDataW'(sig_q),
                                  MaxDataW'(wdata) & byte_mask(MaxStrbW'(wstrb)),
                                  DATA_W));
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sig_q <= '0;
      else         sig_q <= sig_d;
   end

   assign sig = sig_q;

endmodule

// File: rtl/sim_run_controller.sv
// Run controller: sequences the DUT reset release, bounds the run with a cycle
// budget and snoops the memory write port for completion and a write checksum.
module sim_run_controller
   import sim_ctrl_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 32,
   parameter int unsigned       DATA_W       = 32,
   parameter int unsigned       RESET_CYCLES = 1,
   parameter int unsigned       MAX_CYCLES   = 500,
   parameter int unsigned       CNT_W        = 32,
   parameter logic [ADDR_W-1:0] DONE_ADDR    = 32'h1000_0000,
   parameter logic [DATA_W-1:0] PASS_VALUE   = 32'h0000_0001
) (
   input  logic                clk,
   input  logic                resetn,
   output logic                dut_resetn,
   input  logic                mem_valid,
   input  logic                mem_ready,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_wstrb,
   output logic                run_done,
   output logic                run_pass,
   output logic                run_timeout,
   output logic [CNT_W-1:0]    cycle_count,
   output logic [CNT_W-1:0]    write_count,
   output logic [DATA_W-1:0]   checksum
);

   localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] BudgetLast = CNT_W'(MAX_CYCLES - 1);

   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             to_q, to_d;
   logic             dut_rst_q, dut_rst_d;
   logic             wr_fire, done_wr, sig_en;

   assign wr_fire = mem_valid & mem_ready & (|mem_wstrb);
   assign done_wr = wr_fire & (mem_addr == DONE_ADDR);

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cyc_d     = cyc_q;
      wcnt_d    = wcnt_q;
      done_d    = done_q;
      pass_d    = pass_q;
      to_d      = to_q;
      dut_rst_d = dut_rst_q;
      sig_en    = 1'b0;
      unique case (state_q)
         StHold: begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
            if (hold_q == HoldLast) begin
               state_d   = StRun;
               dut_rst_d = 1'b1;
            end
         end
         StRun: begin
            cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
            if (wr_fire) begin
               wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
               sig_en = 1'b1;
            end
            // A done write on the last budget cycle takes priority over timeout.
            if (done_wr) begin
               state_d = StDone;
               done_d  = 1'b1;
               pass_d  = (mem_wdata == PASS_VALUE);
            end else if (cyc_q == BudgetLast) begin
               state_d = StTimeout;
               done_d  = 1'b1;
               to_d    = 1'b1;
            end
         end
         StDone, StTimeout: ;
         default: state_d = StHold;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= StHold;
         hold_q    <= '0;
         cyc_q     <= '0;
         wcnt_q    <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         to_q      <= 1'b0;
         dut_rst_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         cyc_q     <= cyc_d;
         wcnt_q    <= wcnt_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         to_q      <= to_d;
         dut_rst_q <= dut_rst_d;
      end
   end

   write_signature #(
      .DATA_W(DATA_W)
   ) u_sig (
      .clk   (clk),
      .resetn(resetn),
      .en    (sig_en),
      .clr   (state_q == StHold),
      .wdata (mem_wdata),
      .wstrb (mem_wstrb),
      .sig   (checksum)
   );

   assign dut_resetn  = dut_rst_q;
   assign run_done    = done_q;
   assign run_pass    = pass_q;
   assign run_timeout = to_q;
   assign cycle_count = cyc_q;
   assign write_count = wcnt_q;

endmodule
